// File: rtl/out_packet_arbiter.sv
// Outbound packet scheduler for the from_mon path: queues power, audio and
// keyboard/mouse requests and issues one 40-bit packet at a time to the sender.
module out_packet_arbiter #(
    parameter logic [7:0] OP_POWER    = 8'hC0,
    parameter logic [7:0] OP_AUDIO    = 8'h07,
    parameter logic [7:0] OP_KBD      = 8'hC5,
    parameter logic [7:0] OP_MOUSE    = 8'hC6,
    parameter int         GAP_CYCLES  = 4,
    parameter int         AUDIO_BURST = 4
) (
    input  logic        mon_clk,
    input  logic        reset,
    input  logic        power_on_req,
    input  logic        audio_req,
    input  logic        kbd_valid,
    input  logic        kbd_is_mouse,
    input  logic [15:0] kbd_data,
    input  logic        sender_busy,
    output logic [39:0] out_data,
    output logic        out_valid,
    output logic        audio_drop,
    output logic        kbd_drop,
    output logic [1:0]  kbd_level
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    state_t        state_q;
    logic [GW-1:0] gap_q;
    logic          pwr_q, pwr_d;
    logic          aud_q, aud_d;
    logic [16:0]   e0_q, e0_d;
    logic [16:0]   e1_q, e1_d;
    logic [1:0]    level_q, level_d;
    logic [2:0]    burst_q, burst_d;
    logic [39:0]   out_data_q;
    logic          out_valid_q;
    logic          aud_drop_q, aud_drop_d;
    logic          kbd_drop_q, kbd_drop_d;

    logic        idle;
    logic        kbd_nonempty;
    logic        audio_blocked;
    logic        gnt_pwr, gnt_aud, gnt_kbd;
    logic        push_ok;
    logic [7:0]  kbd_op;
    logic [39:0] pkt;

    assign idle          = (state_q == S_IDLE);
    assign kbd_nonempty  = (level_q != 2'd0);
    assign audio_blocked = (burst_q == 3'(AUDIO_BURST)) && kbd_nonempty;

    assign gnt_pwr = idle && pwr_q;
    assign gnt_aud = idle && !pwr_q && aud_q && !audio_blocked;
    assign gnt_kbd = idle && !pwr_q && !gnt_aud && kbd_nonempty;

    // A request arriving on its own grant cycle re-arms the flag.
    assign pwr_d      = (pwr_q && !gnt_pwr) || power_on_req;
    assign aud_d      = (aud_q && !gnt_aud) || audio_req;
    assign aud_drop_d = audio_req && aud_q && !gnt_aud;

    assign push_ok    = kbd_valid && ((level_q != 2'd2) || gnt_kbd);
    assign kbd_drop_d = kbd_valid && !push_ok;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        level_d = level_q;
        if (gnt_kbd) begin
            e0_d    = e1_q;
            level_d = level_q - 2'd1;
        end
        if (push_ok) begin
            if (level_d == 2'd0) e0_d = {kbd_is_mouse, kbd_data};
            else                 e1_d = {kbd_is_mouse, kbd_data};
            level_d = level_d + 2'd1;
        end
    end

    always_comb begin
        burst_d = burst_q;
        if (gnt_kbd || !kbd_nonempty) burst_d = 3'd0;
        else if (gnt_aud && burst_q != 3'd7) burst_d = burst_q + 3'd1;
    end

    assign kbd_op = e0_q[16] ? OP_MOUSE : OP_KBD;

    always_comb begin
        pkt = '0;
        unique case (1'b1)
            gnt_pwr: pkt = {OP_POWER, 32'h0};
            gnt_aud: pkt = {OP_AUDIO, 32'h0};
            gnt_kbd: pkt = {kbd_op, 16'h0, e0_q[15:0]};
            default: pkt = '0;
        endcase
    end

    always_ff @(posedge mon_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            pwr_q       <= 1'b0;
            aud_q       <= 1'b0;
            e0_q        <= '0;
            e1_q        <= '0;
            level_q     <= 2'd0;
            burst_q     <= 3'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            aud_drop_q  <= 1'b0;
            kbd_drop_q  <= 1'b0;
        end else begin
            pwr_q       <= pwr_d;
            aud_q       <= aud_d;
            e0_q        <= e0_d;
            e1_q        <= e1_d;
            level_q     <= level_d;
            burst_q     <= burst_d;
            aud_drop_q  <= aud_drop_d;
            kbd_drop_q  <= kbd_drop_d;
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_pwr || gnt_aud || gnt_kbd) begin
                        out_data_q  <= pkt;
                        out_valid_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (!sender_busy) begin
                        if (GAP_CYCLES == 0) begin
                            state_q <= S_IDLE;
                        end else begin
                            gap_q   <= '0;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) state_q <= S_IDLE;
                    else gap_q <= gap_q + 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign audio_drop = aud_drop_q;
    assign kbd_drop   = kbd_drop_q;
    assign kbd_level  = level_q;

endmodule

// File: tb/tb_out_packet_arbiter.sv
// Scoreboard bench for out_packet_arbiter: expected packets are queued as
// stimulus is driven and matched against each out_valid strobe.
module tb_out_packet_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        power_on_req = 1'b0;
    logic        audio_req = 1'b0;
    logic        kbd_valid = 1'b0;
    logic        kbd_is_mouse = 1'b0;
    logic [15:0] kbd_data = '0;
    logic        sender_busy = 1'b0;
    logic [39:0] out_data;
    logic        out_valid;
    logic        audio_drop;
    logic        kbd_drop;
    logic [1:0]  kbd_level;

    out_packet_arbiter dut (
        .mon_clk      (clk),
        .reset        (reset),
        .power_on_req (power_on_req),
        .audio_req    (audio_req),
        .kbd_valid    (kbd_valid),
        .kbd_is_mouse (kbd_is_mouse),
        .kbd_data     (kbd_data),
        .sender_busy  (sender_busy),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .audio_drop   (audio_drop),
        .kbd_drop     (kbd_drop),
        .kbd_level    (kbd_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];
    int vcyc[$];
    int last_v = -1000;
    int nvalid = 0;
    int ad_cnt = 0;
    int kd_cnt = 0;
    int busy_len = 2;
    bit hold = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Sender model: busy for busy_len cycles after each strobe, or held high.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (hold) begin
                sender_busy = 1'b1;
            end else if (cnt > 0) begin
                sender_busy = 1'b1;
                cnt--;
            end else begin
                sender_busy = 1'b0;
            end
            if (out_valid && !hold) cnt = busy_len;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (audio_drop) ad_cnt++;
            if (kbd_drop) kd_cnt++;
            if (out_valid) begin
                nvalid++;
                vcyc.push_back(cyc);
                if (cyc - last_v < 7) check("spacing", cyc - last_v, 7);
                last_v = cyc;
                if (exp_q.size() == 0) check("unexp_valid", out_valid, 0);
                else check("pkt", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (20) tick();
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!out_valid && n < max) begin
            tick();
            n++;
        end
        if (!out_valid) check("valid_timeout", out_valid, 1);
    endtask

    task automatic kbd_push(input logic m, input logic [15:0] d);
        kbd_valid = 1'b1;
        kbd_is_mouse = m;
        kbd_data = d;
        tick();
        kbd_valid = 1'b0;
    endtask

    task automatic pulse_audio();
        audio_req = 1'b1;
        tick();
        audio_req = 1'b0;
    endtask

    initial begin
        int t0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_adrop", audio_drop, 0);
        check("rst_kdrop", kbd_drop, 0);
        check("rst_level", kbd_level, 0);

        // single audio request, latency and gap
        busy_len = 8;
        while (cyc < 10) tick();
        t0 = cyc;
        vcyc.delete();
        exp_q.push_back(40'h07_0000_0000);
        pulse_audio();
        while (cyc < t0 + 3) tick();
        exp_q.push_back(40'h07_0000_0000);
        pulse_audio();
        drain(100);
        check("t1_nvalid", vcyc.size(), 2);
        if (vcyc.size() >= 2) begin
            check("t1_latency", vcyc[0], t0 + 2);
            check("t1_gap", vcyc[1] >= t0 + 15, 1);
        end

        // simultaneous requesters, fixed priority
        busy_len = 2;
        exp_q.push_back(40'hC0_0000_0000);
        exp_q.push_back(40'h07_0000_0000);
        exp_q.push_back(40'hC5_0000_1234);
        power_on_req = 1'b1;
        audio_req = 1'b1;
        kbd_valid = 1'b1;
        kbd_is_mouse = 1'b0;
        kbd_data = 16'h1234;
        tick();
        power_on_req = 1'b0;
        audio_req = 1'b0;
        kbd_valid = 1'b0;
        tick();
        check("t2_level", kbd_level, 1);
        drain(200);
        check("t2_level_end", kbd_level, 0);

        // audio burst limit while a mouse report waits
        for (int i = 0; i < 4; i++) exp_q.push_back(40'h07_0000_0000);
        exp_q.push_back(40'hC6_0000_BEEF);
        exp_q.push_back(40'h07_0000_0000);
        audio_req = 1'b1;
        kbd_push(1'b1, 16'hBEEF);
        audio_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid(100);
            pulse_audio();
        end
        drain(200);

        // FIFO overflow while sender is stalled
        hold = 1'b1;
        kd_cnt = 0;
        exp_q.push_back(40'h07_0000_0000);
        exp_q.push_back(40'hC5_0000_00A1);
        exp_q.push_back(40'hC5_0000_00A2);
        pulse_audio();
        repeat (5) tick();
        kbd_push(1'b0, 16'h00A1);
        tick();
        kbd_push(1'b0, 16'h00A2);
        tick();
        kbd_push(1'b0, 16'h00A3);
        check("t4_drop_pulse", kbd_drop, 1);
        tick();
        check("t4_drop_once", kbd_drop, 0);
        check("t4_level", kbd_level, 2);
        check("t4_drop_cnt", kd_cnt, 1);
        hold = 1'b0;
        drain(200);

        // audio re-request while pending in WAIT
        hold = 1'b1;
        ad_cnt = 0;
        exp_q.push_back(40'h07_0000_0000);
        exp_q.push_back(40'h07_0000_0000);
        pulse_audio();
        repeat (4) tick();
        pulse_audio();
        check("t5_no_drop", audio_drop, 0);
        tick();
        pulse_audio();
        check("t5_drop_pulse", audio_drop, 1);
        tick();
        check("t5_drop_once", audio_drop, 0);
        hold = 1'b0;
        drain(200);
        check("t5_drop_cnt", ad_cnt, 1);

        // reset in WAIT with a full FIFO
        hold = 1'b1;
        exp_q.push_back(40'h07_0000_0000);
        pulse_audio();
        repeat (4) tick();
        kbd_push(1'b0, 16'h0011);
        kbd_push(1'b1, 16'h0022);
        tick();
        check("t6_level_pre", kbd_level, 2);
        check("t6_sb_pre", exp_q.size(), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_data", out_data, 0);
        check("t6_valid", out_valid, 0);
        check("t6_adrop", audio_drop, 0);
        check("t6_kdrop", kbd_drop, 0);
        check("t6_level", kbd_level, 0);
        t0 = nvalid;
        hold = 1'b0;
        repeat (40) tick();
        check("t6_no_pkt", nvalid, t0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_packet_arbiter.md
# out_packet_arbiter

Schedules every outbound packet towards the NeXT on the `from_mon` path. It collects three requesters: the power-on reply, audio sample requests, and keyboard/mouse reports. It arbitrates between them, builds the 40-bit packet, and hands it to the serial sender one packet at a time, respecting the sender's busy indication and a minimum inter-packet gap. It replaces the free-running combinational encoder, so a request that collides with an in-flight transmission is queued rather than lost.

## Interface
Parameters:
- `OP_POWER`, 8'hC0: opcode byte for the power-on reply.
- `OP_AUDIO`, 8'h07: opcode byte for an audio sample request.
- `OP_KBD`, 8'hC5: opcode byte for a keyboard report.
- `OP_MOUSE`, 8'hC6: opcode byte for a mouse report.
- `GAP_CYCLES`, 4: idle `mon_clk` cycles enforced after the sender drops busy.
- `AUDIO_BURST`, 4: maximum consecutive audio grants while a keyboard entry waits.

Ports:
- `mon_clk`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high.
- `power_on_req`  in  1: one-cycle pulse requesting a power-on reply.
- `audio_req`  in  1: one-cycle pulse requesting an audio sample.
- `kbd_valid`  in  1: one-cycle pulse; a keyboard/mouse report is present.
- `kbd_is_mouse`  in  1: qualifies `kbd_valid`.
- `kbd_data`  in  16: report payload, sampled with `kbd_valid`.
- `sender_busy`  in  1: high while the sender shifts a packet out; rises at most 1 cycle after `out_valid`.
- `out_data`  out  40: packet to the sender.
- `out_valid`  out  1: one-cycle strobe qualifying `out_data`.
- `audio_drop`  out  1: one-cycle pulse; an audio request was discarded.
- `kbd_drop`  out  1: one-cycle pulse; a keyboard report was discarded.
- `kbd_level`  out  2: keyboard FIFO occupancy, 0 to 2.

## Operation
- Pending storage:
  - Power and audio requests each have a 1-bit pending flag.
  - Keyboard reports go into a 2-entry FIFO of {is_mouse, data[15:0]}.
- Packet format:
  - `out_data[39:32]` = opcode; `[31:16]` = 0.
  - `[15:0]` = the keyboard payload, or 0 for power and audio packets.
  - The keyboard opcode is `OP_MOUSE` when is_mouse=1, otherwise `OP_KBD`.
- Arbitration happens only in IDLE. Fixed priority:
  - power first;
  - then audio, unless `burst_cnt == AUDIO_BURST` and the keyboard FIFO is non-empty;
  - then keyboard.
- `burst_cnt` (3 bits, saturating):
  - increments on each audio grant while the keyboard FIFO is non-empty;
  - clears on any keyboard grant and whenever the FIFO is empty.
- FSM:
  - IDLE: if anything is pending, register the packet, pulse `out_valid`, clear the granted flag or pop the FIFO, and go to ISSUE.
  - ISSUE: one cycle with busy ignored, then WAIT.
  - WAIT: stay while `sender_busy`=1. When it is 0, go to GAP, or to IDLE if `GAP_CYCLES`=0.
  - GAP: count `GAP_CYCLES` cycles, then IDLE.
- Boundary rules:
  - A new request on the same cycle its flag is granted keeps the flag set, so the request is served again later.
  - `audio_req` while audio is already pending and not being granted: `audio_drop` pulses and the flag stays 1.
  - A repeated `power_on_req` while pending is silently merged; no drop is reported.
  - `kbd_valid` with the FIFO full and no pop on that cycle: the new report is discarded, `kbd_drop` pulses, and the older entries are kept.
  - Push and pop on the same cycle with the FIFO full: the push is accepted and the level stays at 2.
  - A non-empty FIFO with `sender_busy` stuck high stalls in WAIT indefinitely. There is no timeout.

## Timing
- Reset values:
  - `out_data`=0, `out_valid`=0, `audio_drop`=0, `kbd_drop`=0, `kbd_level`=0.
  - FSM in IDLE; pending flags, FIFO, `burst_cnt` and gap counter all cleared.
- Reset mid-packet aborts scheduling immediately. `out_valid` is 0 from the cycle after the reset cycle, and queued requests are lost.
- All outputs are registered.
- Latency: a request pulse in cycle N, with the FSM idle and nothing else pending, produces `out_valid`=1 in cycle N+2.
- Throughput: back-to-back packets are at least 3 + `GAP_CYCLES` cycles apart, even when `sender_busy` never rises.
- `audio_drop` and `kbd_drop` pulse in the cycle after the offending request.
- `kbd_level` updates in the cycle after a push or pop.

## Test plan
- Reset, then a single `audio_req` at cycle 10. Required: `out_valid` only at cycle 12 with `out_data`=40'h07_0000_0000; then `sender_busy` high cycles 13–20 and the next grant no earlier than cycle 25 (GAP_CYCLES=4).
- `power_on_req`, `audio_req`, and `kbd_valid` (data 16'h1234, mouse=0) all in one cycle. Required grant order: C0_0000_0000, then 07_0000_0000, then C5_0000_1234.
- Audio request re-issued after every packet while one keyboard entry (mouse=1, 16'hBEEF) waits. Required: exactly 4 audio packets, then C6_0000_BEEF, then audio resumes.
- Three `kbd_valid` pulses while `sender_busy` is held high. Required: `kbd_level`=2, one `kbd_drop` pulse, and the first two payloads sent in order after busy falls.
- Second `audio_req` while audio is pending and the FSM is in WAIT. Required: `audio_drop` pulses once and only one audio packet follows.
- `reset` asserted in WAIT with the FIFO holding 2 entries. Required: all outputs 0 the next cycle, `kbd_level`=0, and no packet issued after reset releases.
